// File: rtl/ctrl_pkg.sv
// Shared types and ISA constants for the ctrl_decode_fsm control unit.
// Instruction fields: op=ir[15:12] rdest=ir[11:8] ext=ir[7:4] rsrc=ir[3:0].
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_ALU,
    K_JAL,
    K_JCOND,
    K_BCOND,
    K_ILL
  } kind_t;

  typedef enum logic [1:0] {
    B_RS,
    B_IMM8,
    B_IMM4
  } bsel_t;

  typedef struct packed {
    kind_t      kind;
    bsel_t      bsel;
    logic [7:0] opc;
    logic       wr;
    logic       upd;
  } dec_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_SPEC  = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_ADDUI = 4'h6;
  localparam logic [3:0] OP_ADDCI = 4'h7;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_SUBCI = 4'hA;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_LUI   = 4'hF;

  localparam logic [3:0] EXT_AND   = 4'h1;
  localparam logic [3:0] EXT_ADD   = 4'h5;
  localparam logic [3:0] EXT_SUB   = 4'h9;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;
  localparam logic [3:0] EXT_LSH   = 4'h4;
  localparam logic [3:0] EXT_ASHU  = 4'h6;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

  function automatic logic is_imm_op(
    input logic [3:0] op
  );
    return op inside {
      OP_ANDI, OP_ORI, OP_XORI,
      OP_ADDI, OP_ADDUI, OP_ADDCI,
      OP_SUBI, OP_SUBCI, OP_CMPI,
      OP_MOVI, OP_LUI
    };
  endfunction

  // Only add/sub/compare/and families move the flags.
  function automatic logic psr_upd(
    input logic [7:0] opc
  );
    return opc inside {
      {OP_RTYPE, EXT_ADD}, {OP_ADDI, 4'h0},
      {OP_RTYPE, EXT_SUB}, {OP_SUBI, 4'h0},
      {OP_RTYPE, EXT_CMP}, {OP_CMPI, 4'h0},
      {OP_RTYPE, EXT_AND}, {OP_ANDI, 4'h0}
    };
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator.
// Pure combinational: PSR flags and 4-bit condition to taken.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [4:0] psr,
  input  logic [3:0] cond,
  output logic       taken
);

  logic c, l, f, z, n;

  assign c = psr[PSR_C];
  assign l = psr[PSR_L];
  assign f = psr[PSR_F];
  assign z = psr[PSR_Z];
  assign n = psr[PSR_N];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      CC_EQ: taken = z;
      CC_NE: taken = ~z;
      CC_CS: taken = c;
      CC_CC: taken = ~c;
      CC_HI: taken = l;
      CC_LS: taken = ~l;
      CC_GT: taken = n;
      CC_LE: taken = ~n;
      CC_FS: taken = f;
      CC_FC: taken = ~f;
      CC_LO: taken = ~l & ~z;
      CC_HS: taken = l | z;
      CC_LT: taken = ~n & ~z;
      CC_GE: taken = n | z;
      CC_UC: taken = 1'b1;
      CC_NV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_fsm.sv
// Multi-cycle fetch/decode/execute/writeback control unit.
// Define ILLEGAL_TRAP_EN to halt on illegal instructions until reset.
module ctrl_decode_fsm
  import ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_W     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [15:0]     instr_data,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      rf_raddr_a,
  output logic [3:0]      rf_raddr_b,
  input  logic [15:0]     rf_rdata_a,
  input  logic [15:0]     rf_rdata_b,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [15:0]     rf_wdata,
  output logic [7:0]      alu_opcode,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  input  logic [15:0]     alu_c,
  input  logic [4:0]      alu_flags,
  output logic [4:0]      psr,
  output logic            illegal
);

  state_t state, state_n;

  logic [15:0]     ir;
  logic [15:0]     b_q;
  logic [15:0]     c_q;
  logic            taken_q;
  logic            taken;
  dec_t            dec;
  logic [15:0]     b_n;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_br;
  logic [PC_W-1:0] pc_n;
  logic            ill_wb;

  logic [3:0] op;
  logic [3:0] ext;

  assign op  = ir[15:12];
  assign ext = ir[7:4];

  always_comb begin
    dec      = '0;
    dec.kind = K_ILL;
    dec.bsel = B_RS;
    dec.opc  = {op, ext};
    unique case (1'b1)
      op == OP_RTYPE:
        dec.kind = K_ALU;
      is_imm_op(op): begin
        dec.kind = K_ALU;
        dec.bsel = B_IMM8;
        dec.opc  = {op, 4'h0};
      end
      op == OP_SHIFT &&
      (ext == EXT_LSH || ext == EXT_ASHU):
        dec.kind = K_ALU;
      op == OP_SHIFT && ext[3:2] == 2'b00: begin
        dec.kind = K_ALU;
        dec.bsel = B_IMM4;
      end
      op == OP_SPEC && ext == EXT_JAL:
        dec.kind = K_JAL;
      op == OP_SPEC && ext == EXT_JCOND:
        dec.kind = K_JCOND;
      op == OP_BCOND:
        dec.kind = K_BCOND;
      default: ;
    endcase
    dec.wr  = (dec.kind == K_ALU) &&
              (dec.opc != {OP_RTYPE, EXT_CMP}) &&
              (dec.opc != {OP_CMPI, 4'h0});
    dec.upd = (dec.kind == K_ALU) && psr_upd(dec.opc);
  end

  always_comb begin
    b_n = rf_rdata_b;
    unique case (dec.bsel)
      B_IMM8:  b_n = {8'h00, ir[7:0]};
      B_IMM4:  b_n = {12'h000, ir[3:0]};
      default: b_n = rf_rdata_b;
    endcase
  end

  // Condition is checked against the PSR before this instruction's update.
  cond_eval u_cond (
    .psr   (psr),
    .cond  (ir[11:8]),
    .taken (taken)
  );

  assign pc_inc = pc + PC_W'(1);
  assign pc_br  = pc + {{8{ir[7]}}, ir[7:0]};
  assign ill_wb = (state == S_WB) && (dec.kind == K_ILL);

  always_comb begin
    pc_n = pc_inc;
    unique case (dec.kind)
      K_JAL:   pc_n = b_q;
      K_JCOND: pc_n = taken_q ? b_q : pc_inc;
      K_BCOND: pc_n = taken_q ? pc_br : pc_inc;
      default: pc_n = pc_inc;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH:  if (instr_valid) state_n = S_DECODE;
      S_DECODE: state_n = S_EXEC;
      S_EXEC:   state_n = S_WB;
`ifdef ILLEGAL_TRAP_EN
      S_WB:     state_n = ill_wb ? S_HALT : S_FETCH;
      S_HALT:   state_n = S_HALT;
`else
      S_WB:     state_n = S_FETCH;
`endif
      default:  state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      psr        <= '0;
      ir         <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      b_q        <= '0;
      c_q        <= '0;
      taken_q    <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        S_FETCH:
          if (instr_valid) ir <= instr_data;
        S_DECODE: begin
          alu_opcode <= dec.opc;
          alu_a      <= rf_rdata_a;
          alu_b      <= b_n;
          b_q        <= rf_rdata_b;
        end
        S_EXEC: begin
          c_q     <= alu_c;
          taken_q <= taken;
          if (dec.upd) psr <= alu_flags;
        end
        S_WB: begin
`ifdef ILLEGAL_TRAP_EN
          if (!ill_wb) pc <= pc_n;
`else
          pc <= pc_n;
`endif
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (state == S_FETCH);
  assign rf_raddr_a  = ir[11:8];
  assign rf_raddr_b  = ir[3:0];
  assign rf_waddr    = ir[11:8];
  assign rf_we       = (state == S_WB) &&
                       (dec.wr || dec.kind == K_JAL);
  assign rf_wdata    = (dec.kind == K_JAL) ?
                       pc_inc : c_q;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = ill_wb || (state == S_HALT);
`else
  assign illegal = ill_wb;
`endif

endmodule

// File: doc/ctrl_decode_fsm.md
Name: ctrl_decode_fsm

Overview:
Multi-cycle control unit that drives the ALU's opcode/operand side and consumes its flags. It fetches 16-bit instructions over a valid/ready handshake, decodes them into ALU opcodes, register addresses and immediates, and holds the PSR flag register. It evaluates Bcond/Jcond/JAL, owns the PC and sequences register-file writeback.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_W, 16, PC width; fixed at 16 for this ISA

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction word present on instr_data
instr_data  in  16  instruction word at address pc
instr_ready  out  1  high only in FETCH; transfer when instr_valid & instr_ready
pc  out  16  current program counter / fetch address
rf_raddr_a  out  4  Rdest read address (instr[11:8])
rf_raddr_b  out  4  Rsrc read address (instr[3:0])
rf_rdata_a  in  16  combinational register-file read data A
rf_rdata_b  in  16  combinational register-file read data B
rf_we  out  1  register-file write strobe, one-cycle pulse
rf_waddr  out  4  write address (Rdest)
rf_wdata  out  16  write data
alu_opcode  out  8  opcode to ALU
alu_a  out  16  ALU source A
alu_b  out  16  ALU source B
alu_c  in  16  ALU result
alu_flags  in  5  ALU flags {C,L,F,Z,N}, bits 4..0
psr  out  5  registered PSR, same bit order
illegal  out  1  one-cycle pulse on an unsupported instruction

Behaviour:
- Reset: state=FETCH, pc=RESET_PC, psr=0, ir=0, rf_we=0, illegal=0, alu_opcode/alu_a/alu_b=0. Reset in any state aborts the instruction; no write occurs.
- States FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH. Minimum 4 cycles per instruction; FETCH stalls while instr_valid=0.
- FETCH: instr_ready=1. On handshake, latch ir=instr_data and go to DECODE.
- DECODE: register rdata_a/rdata_b.
  - R-type (op=0000, and op=1000 with ext 0100/0110): alu_opcode={op,ext}, alu_b=Rsrc data.
  - Immediate (op 0001,0010,0011,0101,0110,0111,1001,1010,1011,1101,1111): alu_opcode={op,4'b0000}, alu_b={8'h00,imm8}. The ALU performs any sign extension.
  - LSHI/ASHUI (op 1000, ext 000x/001x): alu_opcode={op,ext}, alu_b={12'h000,ir[3:0]}.
  - alu_a=Rdest data in all cases.
- EXECUTE: ALU inputs stable.
  - PSR updates from alu_flags only for ADD/ADDI/SUB/SUBI/CMP/CMPI/AND/ANDI. All other opcodes hold the PSR.
  - Latch alu_c. Evaluate the condition from ir[11:8] against the pre-update PSR.
- WRITEBACK:
  - rf_we=1 for ALU ops except CMP/CMPI, with rf_wdata=latched alu_c.
  - JAL: rf_wdata=pc+1, pc=Rsrc data.
  - Bcond (op 1100) taken: pc=pc+sext(ir[7:0]); otherwise pc=pc+1.
  - Jcond (op 0100, ext 1100) taken: pc=Rsrc data.
  - All other instructions: pc=pc+1. PC arithmetic wraps modulo 2^16.
- Condition codes: EQ 0000 Z; NE 0001 ~Z; CS 0010 C; CC 0011 ~C; HI 0100 L; LS 0101 ~L; GT 0110 N; LE 0111 ~N; FS 1000 F; FC 1001 ~F; LO 1010 ~L&~Z; HS 1011 L|Z; LT 1100 ~N&~Z; GE 1101 N|Z; UC 1110 always; 1111 never.
- LOAD/STOR and unlisted encodings: illegal pulses in WRITEBACK, no rf write, pc=pc+1.
- Branch target computed as pc+1 wraps: 16'hFFFF -> 16'h0000.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an illegal instruction enters a HALT state. instr_ready=0, pc frozen, illegal held high until reset.
- Undefined: illegal pulses for one cycle and execution continues (NOP semantics).

Decomposition:
- Package ctrl_pkg: state enum; op/ext nibble constants; condition-code constants; PSR bit indices C=4, L=3, F=2, Z=1, N=0.
- Sub-module cond_eval: combinational (psr, cond) -> taken. Instantiated once.

Test Plan:
- ADD R1,R2 with R1=16'h7FFF, R2=1 -> alu_opcode=8'h05; rf_we pulse with waddr=1, wdata=16'h8000; psr[F]=1, psr[C]=0.
- CMPI R3,#5 with R3=3, then BEQ -> no rf_we; psr[L]=1, Z=0; branch not taken, pc advances by 1.
- BNE disp=8'hFE at pc=16'h0010 with Z=0 -> pc=16'h000E; then UC Jcond to R4=16'h1234 -> pc=16'h1234.
- JAL R14,R5 at pc=16'h0020, R5=16'h0100 -> R14 written 16'h0021, pc=16'h0100.
- instr_valid held low 5 cycles in FETCH -> state and pc unchanged; reset asserted in EXECUTE -> no rf_we, pc=RESET_PC next cycle.
- LOAD encoding -> illegal pulse, pc+1. With ILLEGAL_TRAP_EN: illegal stays high, instr_ready=0 until reset.
